// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: a programmable step timer advances a walk, bounce,
// binary-count or blink-all pattern on the LED bank, with selectable pin polarity.
module led_pattern_seq #(
  parameter int LED_NUM    = 4,
  parameter int CNT_W      = 32,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic               dir,
  input  logic [CNT_W-1:0]   period,
  output logic [LED_NUM-1:0] led,
  output logic               step_o
);

  typedef enum logic [1:0] {
    MODE_WALK   = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_COUNT  = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_t;

  mode_t              mode_in;
  mode_t              mode_q;
  mode_t              mode_q_nxt;
  logic [LED_NUM-1:0] pat;
  logic [LED_NUM-1:0] pat_nxt;
  logic [LED_NUM-1:0] adv_pat;
  logic [LED_NUM-1:0] bounce_pat;
  logic [CNT_W-1:0]   timer;
  logic [CNT_W-1:0]   timer_nxt;
  logic [CNT_W-1:0]   last_tick;
  logic               bdir;
  logic               bdir_nxt;
  logic               adv_bdir;
  logic               bounce_up;
  logic               mode_chg;
  logic               step_nxt;

  function automatic logic [LED_NUM-1:0] init_pat(input mode_t m);
    case (m)
      MODE_COUNT: init_pat = '0;
      MODE_BLINK: init_pat = '1;
      default:    init_pat = LED_NUM'(1);
    endcase
  endfunction

  assign mode_in   = mode_t'(mode);
  assign mode_chg  = (mode_in != mode_q);
  // Periods of 0 and 1 both mean "step every cycle".
  assign last_tick = (period < CNT_W'(2)) ? '0 : period - CNT_W'(1);

  // Next pattern if a step happens this cycle. Bounce reverses early if the
  // lit bit already sits at the end it is heading for, so it never drops off.
  always_comb begin
    adv_pat    = pat;
    adv_bdir   = bdir;
    bounce_up  = (!bdir && !pat[LED_NUM-1]) || (bdir && pat[0]);
    bounce_pat = bounce_up ? (pat << 1) : (pat >> 1);
    case (mode_q)
      MODE_WALK: begin
        if (dir)
          adv_pat = (pat >> 1) | (pat << (LED_NUM - 1));
        else
          adv_pat = (pat << 1) | (pat >> (LED_NUM - 1));
      end
      MODE_BOUNCE: begin
        if (LED_NUM > 1) begin
          adv_pat  = bounce_pat;
          adv_bdir = bounce_up ? bounce_pat[LED_NUM-1] : !bounce_pat[0];
        end
      end
      MODE_COUNT: begin
        adv_pat = dir ? (pat - LED_NUM'(1)) : (pat + LED_NUM'(1));
      end
      default: begin
        adv_pat = ~pat;
      end
    endcase
  end

  // Mode change restarts from the new initial pattern and outranks a due step.
  always_comb begin
    mode_q_nxt = mode_q;
    pat_nxt    = pat;
    timer_nxt  = timer;
    bdir_nxt   = bdir;
    step_nxt   = 1'b0;
    if (mode_chg) begin
      mode_q_nxt = mode_in;
      pat_nxt    = init_pat(mode_in);
      timer_nxt  = '0;
      if (mode_in == MODE_BOUNCE)
        bdir_nxt = dir;
    end else if (en) begin
      if (timer >= last_tick) begin
        timer_nxt = '0;
        pat_nxt   = adv_pat;
        bdir_nxt  = adv_bdir;
        step_nxt  = 1'b1;
      end else begin
        timer_nxt = timer + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer  <= '0;
      mode_q <= mode_in;
      pat    <= init_pat(mode_in);
      bdir   <= dir;
      step_o <= 1'b0;
    end else begin
      timer  <= timer_nxt;
      mode_q <= mode_q_nxt;
      pat    <= pat_nxt;
      bdir   <= bdir_nxt;
      step_o <= step_nxt;
    end
  end

  assign led = ACTIVE_LOW ? ~pat : pat;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Bench for led_pattern_seq: directed scenarios plus a randomized run, all
// checked against a position/counter based reference model.
module tb_led_pattern_seq;

  localparam int N  = 4;
  localparam int CW = 32;
  localparam bit AL = 1'b1;

  logic          clk;
  logic          rst;
  logic          en;
  logic [1:0]    mode;
  logic          dir;
  logic [CW-1:0] period;
  logic [N-1:0]  led;
  logic          step_o;

  int total;
  int bad;

  // Reference model state: which LED is lit, a counter value, blink phase.
  int m_mode;
  int m_pos;
  int m_cnt;
  bit m_lit;
  bit m_bdir;
  int m_wait;
  bit m_step;

  led_pattern_seq #(.LED_NUM(N), .CNT_W(CW), .ACTIVE_LOW(AL)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir),
    .period(period), .led(led), .step_o(step_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void m_load(input int md);
    m_mode = md;
    m_pos  = 0;
    m_cnt  = 0;
    m_lit  = 1'b1;
    m_wait = 0;
    m_step = 1'b0;
    if (md == 1) m_bdir = dir;
  endfunction

  function automatic logic [N-1:0] m_pat();
    logic [N-1:0] r;
    case (m_mode)
      2:       r = N'(m_cnt);
      3:       r = m_lit ? '1 : '0;
      default: r = N'(1 << m_pos);
    endcase
    return r;
  endfunction

  function automatic void m_advance();
    int v;
    case (m_mode)
      0: m_pos = dir ? (m_pos + N - 1) % N : (m_pos + 1) % N;
      1: begin
        v = m_bdir ? -1 : 1;
        if (N > 1) begin
          if (m_pos + v < 0 || m_pos + v > N - 1) v = -v;
          m_pos = m_pos + v;
          if (m_pos == N - 1)  m_bdir = 1'b1;
          else if (m_pos == 0) m_bdir = 1'b0;
          else                 m_bdir = (v < 0);
        end
      end
      2: m_cnt = (m_cnt + (dir ? (1 << N) - 1 : 1)) % (1 << N);
      default: m_lit = !m_lit;
    endcase
  endfunction

  function automatic void model_edge();
    int p;
    p = (period < 2) ? 1 : int'(period);
    if (rst) begin
      m_load(int'(mode));
      m_bdir = dir;
    end else if (int'(mode) != m_mode) begin
      m_load(int'(mode));
    end else if (en) begin
      if (m_wait + 1 >= p) begin
        m_advance();
        m_wait = 0;
        m_step = 1'b1;
      end else begin
        m_wait = m_wait + 1;
        m_step = 1'b0;
      end
    end else begin
      m_step = 1'b0;
    end
  endfunction

  task automatic check_vec(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag);
    logic [N-1:0] p;
    p = m_pat();
    check_vec({tag, "_led"}, led, AL ? ~p : p);
    check_bit({tag, "_step"}, step_o, m_step);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_output(tag);
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  logic [N-1:0] walk_exp   [4];
  logic [N-1:0] bounce_exp [8];

  initial begin
    total = 0;
    bad   = 0;
    m_mode = 0; m_pos = 0; m_cnt = 0; m_lit = 1'b0; m_bdir = 1'b0; m_wait = 0; m_step = 1'b0;
    walk_exp   = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    bounce_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

    // Reset and walk
    rst = 1'b1; en = 1'b1; mode = 2'd0; dir = 1'b0; period = 4;
    tick("reset");
    check_vec("reset_led_const", led, 4'b1110);
    check_bit("reset_step_const", step_o, 1'b0);
    rst = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      tick("walk");
      if (e % 4 == 0) begin
        check_vec("walk_led_const", led, walk_exp[e/4 - 1]);
        check_bit("walk_step_const", step_o, 1'b1);
      end else begin
        check_bit("walk_nostep_const", step_o, 1'b0);
      end
    end

    // Bounce at period 1
    mode = 2'd1; period = 1;
    tick("bounce_load");
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick("bounce");
      check_vec("bounce_pat_const", ~led, bounce_exp[i]);
      check_bit("bounce_step_const", step_o, (i > 0));
    end

    // Count down then up
    mode = 2'd2; dir = 1'b1; period = 2;
    tick("count_load");
    ticks("count", 2);
    check_vec("count_down1", ~led, 4'b1111);
    ticks("count", 2);
    check_vec("count_down2", ~led, 4'b1110);
    dir = 1'b0;
    ticks("count", 2);
    check_vec("count_up", ~led, 4'b1111);

    // Pause for three cycles with timer at 2
    mode = 2'd0; period = 4;
    tick("pause_load");
    ticks("pause_pre", 2);
    en = 1'b0;
    ticks("pause", 3);
    check_vec("pause_led", led, 4'b1110);
    en = 1'b1;
    tick("pause_resume");
    check_bit("pause_nostep", step_o, 1'b0);
    tick("pause_resume");
    check_bit("pause_step", step_o, 1'b1);
    check_vec("pause_led2", led, 4'b1101);

    // Mode change on the cycle a step is due
    ticks("due", 3);
    mode = 2'd3;
    tick("mchg");
    check_bit("mchg_step", step_o, 1'b0);
    check_vec("mchg_pat", ~led, 4'b1111);
    ticks("blink_wait", 3);
    tick("blink");
    check_bit("blink_step", step_o, 1'b1);
    check_vec("blink_pat", ~led, 4'b0000);

    // Lowering the period mid-count
    period = 100;
    ticks("long", 50);
    period = 4;
    tick("lower");
    check_bit("lower_step", step_o, 1'b1);

    // Reset mid-count in count mode
    mode = 2'd2; dir = 1'b0; period = 2;
    tick("cnt_load");
    ticks("cnt", 10);
    check_vec("cnt_0101", ~led, 4'b0101);
    tick("cnt");
    rst = 1'b1;
    tick("midrst");
    check_vec("midrst_pat", ~led, 4'b0000);
    check_bit("midrst_step", step_o, 1'b0);
    rst = 1'b0;
    tick("postrst");
    check_bit("postrst_nostep", step_o, 1'b0);
    tick("postrst");
    check_bit("postrst_step", step_o, 1'b1);
    check_vec("postrst_pat", ~led, 4'b0001);

    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(63) == 0);
      en  = ($urandom_range(7) != 0);
      if ($urandom_range(31) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(15) == 0) dir  = 1'($urandom_range(1));
      if ($urandom_range(31) == 0) period = CW'($urandom_range(7));
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
